// File: rtl/uart_serial_rx.sv
// rtl/uart_serial_rx.sv - 16x oversampled UART receiver with framing/overrun detection and output FIFO.
// Optional even-parity checking is enabled by defining UART_SERIAL_RX_PARITY_EN.
module uart_serial_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 srx_pad_i,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_SERIAL_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state, state_n;
  logic                 sync1, rxs;
  logic [DIV_WIDTH-1:0] tcnt, div_eff;
  logic                 tick;
  logic [3:0]           scnt, scnt_n;
  logic [2:0]           bitn, bitn_n;
  logic [7:0]           shreg, shreg_n;
  logic                 push_req, fe_n;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 full, empty, pop, do_push;
`ifdef UART_SERIAL_RX_PARITY_EN
  logic                 pe_n;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= srx_pad_i;
      rxs   <= sync1;
    end
  end

  // Free-running down counter; a new divisor is picked up on the next reload.
  assign div_eff = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  assign tick    = (tcnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     tcnt <= '0;
    else if (tick) tcnt <= div_eff - DIV_WIDTH'(1);
    else           tcnt <= tcnt - DIV_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      scnt  <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    scnt_n   = tick ? scnt + 4'd1 : scnt;
    bitn_n   = bitn;
    shreg_n  = shreg;
    push_req = 1'b0;
    fe_n     = 1'b0;
`ifdef UART_SERIAL_RX_PARITY_EN
    pe_n     = 1'b0;
`endif
    case (state)
      IDLE: if (!rxs) begin
        scnt_n  = '0;
        state_n = START;
      end
      START: if (tick && scnt == 4'd7) begin
        if (rxs) state_n = IDLE;
        else begin
          scnt_n  = '0;
          bitn_n  = '0;
          state_n = DATA;
        end
      end
      DATA: if (tick && scnt == 4'd15) begin
        shreg_n = {rxs, shreg[7:1]};
        bitn_n  = bitn + 3'd1;
`ifdef UART_SERIAL_RX_PARITY_EN
        if (bitn == 3'd7) state_n = PARITY;
`else
        if (bitn == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_SERIAL_RX_PARITY_EN
      PARITY: if (tick && scnt == 4'd15) begin
        pe_n    = ^{shreg, rxs};
        state_n = STOP;
      end
`endif
      STOP: if (tick && scnt == 4'd15) begin
        if (rxs) begin
          push_req = 1'b1;
          state_n  = IDLE;
        end else begin
          fe_n    = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Full: MSBs differ while the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = rx_valid && rx_ready;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      frame_err <= fe_n;
      overrun   <= push_req && full && !pop;
    end
  end

`ifdef UART_SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) parity_err <= 1'b0;
    else       parity_err <= pe_n;
  end
`endif

  assign rx_data  = mem[rptr[AW-1:0]];
  assign rx_valid = !empty;
  assign busy     = (state != IDLE);

endmodule
